// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side signals of the instruction cache.
//   IF side : if_to_ic_valid, if_to_ic_pc  -> cache
//             ic_to_if_hit, ic_to_if_inst  <- cache
//   MC side : ic_to_mc_request, ic_to_mc_pc <- cache
//             mc_to_ic_rdy, mc_dout         -> cache
// Modport slave is the cache; modport master is its environment
// (fetch stage plus memory controller).
interface icache_if;
  logic        if_to_ic_valid;
  logic [31:0] if_to_ic_pc;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_inst;
  logic        ic_to_mc_request;
  logic [31:0] ic_to_mc_pc;
  logic        mc_to_ic_rdy;
  logic [31:0] mc_dout;

  modport slave (
    input  if_to_ic_valid, if_to_ic_pc, mc_to_ic_rdy, mc_dout,
    output ic_to_if_hit, ic_to_if_inst, ic_to_mc_request, ic_to_mc_pc
  );

  modport master (
    output if_to_ic_valid, if_to_ic_pc, mc_to_ic_rdy, mc_dout,
    input  ic_to_if_hit, ic_to_if_inst, ic_to_mc_request, ic_to_mc_pc
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache.
//   clk_in  : rising-edge clock
//   rst_in  : asynchronous active-high reset (clears valid bits, request, FSM)
//   rdy_in  : global enable; low freezes every register and array
//   clr_in  : pipeline flush; suppresses delivery to IF, never aborts a fill
//   bus     : icache_if.slave -- IF lookup (combinational hit/inst) and the
//             registered request/address handshake to the memory controller
// A miss raises the request one cycle later and holds it until the
// one-cycle mc_to_ic_rdy pulse, which installs the line and forwards the
// word to IF in that same cycle.
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  input  logic    clr_in,
  icache_if.slave bus
);

  localparam int LINES    = int'(32'd1 << INDEX_BITS);
  localparam int TAG_BITS = int'(32'd30) - INDEX_BITS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t                state_r;
  logic [LINES-1:0]      valid_r;
  logic [TAG_BITS-1:0]   tag_r  [LINES];
  logic [31:0]           data_r [LINES];
  logic [31:2]           miss_pc_r;
  logic                  req_r;

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic                  lookup_hit_s;
  logic                  fill_s;
  logic                  fwd_s;
  logic                  hit_s;
  logic [31:0]           inst_s;
  logic                  unused_s;

  assign idx_s      = bus.if_to_ic_pc[INDEX_BITS+1:2];
  assign tag_s      = bus.if_to_ic_pc[31:INDEX_BITS+2];
  assign fill_idx_s = miss_pc_r[INDEX_BITS+1:2];
  assign fill_tag_s = miss_pc_r[31:INDEX_BITS+2];
  // Byte offset within the word plays no part in lookup.
  assign unused_s   = ^bus.if_to_ic_pc[1:0];

  assign lookup_hit_s = bus.if_to_ic_valid & valid_r[idx_s] &
                        (tag_r[idx_s] == tag_s) & rdy_in & ~clr_in;
  // A fill completes regardless of clr_in: the controller cannot abort.
  assign fill_s = (state_r == MISS) & bus.mc_to_ic_rdy & rdy_in & ~rst_in;
  assign fwd_s  = fill_s & bus.if_to_ic_valid & ~clr_in &
                  (bus.if_to_ic_pc[31:2] == miss_pc_r);

  // IF response: forwarded fill word wins over an array hit, else zeros.
  always_comb begin
    hit_s  = 1'b0;
    inst_s = 32'h0000_0000;
    if (rst_in) begin
      hit_s  = 1'b0;
      inst_s = 32'h0000_0000;
    end else if (fwd_s) begin
      hit_s  = 1'b1;
      inst_s = bus.mc_dout;
    end else if (lookup_hit_s) begin
      hit_s  = 1'b1;
      inst_s = data_r[idx_s];
    end else begin
      hit_s  = 1'b0;
      inst_s = 32'h0000_0000;
    end
  end

  assign bus.ic_to_if_hit     = hit_s;
  assign bus.ic_to_if_inst    = inst_s;
  assign bus.ic_to_mc_request = req_r;
  assign bus.ic_to_mc_pc      = {miss_pc_r, 2'b00};

  // Miss FSM: owns valid bits, the request flag and the latched miss address.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r   <= IDLE;
      valid_r   <= {LINES{1'b0}};
      req_r     <= 1'b0;
      miss_pc_r <= {30{1'b0}};
    end else if (rdy_in) begin
      case (state_r)
        IDLE: begin
          if (bus.if_to_ic_valid && !clr_in && !lookup_hit_s) begin
            miss_pc_r <= bus.if_to_ic_pc[31:2];
            req_r     <= 1'b1;
            state_r   <= MISS;
          end
        end
        MISS: begin
          // Request stays up whatever IF does, until the data arrives.
          if (bus.mc_to_ic_rdy) begin
            valid_r[fill_idx_s] <= 1'b1;
            req_r               <= 1'b0;
            state_r             <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data arrays: written only by a fill, no reset needed (valid guards them).
  always_ff @(posedge clk_in) begin
    if (fill_s) begin
      tag_r[fill_idx_s]  <= fill_tag_s;
      data_r[fill_idx_s] <= bus.mc_dout;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench for icache (INDEX_BITS = 8).
// Each stimulus cycle drives inputs and queues the hand-computed response
// for that cycle; an independent monitor pops and compares on the falling
// edge.
module tb_icache;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;
  logic clr_in = 1'b0;

  icache_if bus ();

  icache #(.INDEX_BITS(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clr_in (clr_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        hit;
    logic [31:0] inst;
    logic        req;
    logic [31:0] mcpc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total_cnt++;
      if (bus.ic_to_if_hit !== e.hit || bus.ic_to_if_inst !== e.inst ||
          bus.ic_to_mc_request !== e.req || bus.ic_to_mc_pc !== e.mcpc) begin
        $display("FAIL %s: got hit=%b inst=%h req=%b mcpc=%h, want hit=%b inst=%h req=%b mcpc=%h",
                 e.nm, bus.ic_to_if_hit, bus.ic_to_if_inst, bus.ic_to_mc_request,
                 bus.ic_to_mc_pc, e.hit, e.inst, e.req, e.mcpc);
      end else begin
        pass_cnt++;
      end
    end
  end

  // Drive one cycle of inputs, queue its expected response, advance a cycle.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic clr,
                     input logic rdy, input logic mr, input logic [31:0] dout,
                     input logic eh, input logic [31:0] ei, input logic ereq,
                     input logic [31:0] empc, input string nm);
    exp_t e;
    bus.if_to_ic_valid = v;
    bus.if_to_ic_pc    = pc;
    clr_in             = clr;
    rdy_in             = rdy;
    bus.mc_to_ic_rdy   = mr;
    bus.mc_dout        = dout;
    e.hit  = eh;
    e.inst = ei;
    e.req  = ereq;
    e.mcpc = empc;
    e.nm   = nm;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    bus.if_to_ic_valid = 1'b0;
    bus.if_to_ic_pc    = 32'h0;
    bus.mc_to_ic_rdy   = 1'b0;
    bus.mc_dout        = 32'h0;
    @(posedge clk_in);
    #1;
    //  v     pc            clr   rdy   mr    dout          hit   inst          req   mcpc
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "reset_state");
    rst_in = 1'b0;
    // Cold miss, request, forward on rdy, hit afterwards.
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "cold_miss");
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10, "req_raised");
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b1, 32'h00500093, 1'b1, 32'h00500093, 1'b1, 32'h10, "fill_forward");
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b0, 32'h10, "hit_after_fill");
    cyc(1'b0, 32'h00000010, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h10, "stray_rdy_idle");
    // Conflict eviction at index 4, with hit-under-miss on the old line.
    cyc(1'b1, 32'h00000410, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h10, "miss_410");
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00500093, 1'b1, 32'h410,"hit_under_miss");
    cyc(1'b1, 32'h00000410, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 32'h410,"fill_410");
    cyc(1'b1, 32'h00000410, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h12345678, 1'b0, 32'h410,"hit_410");
    cyc(1'b1, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h410,"evicted_10");
    cyc(1'b0, 32'h00000010, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h10, "re_request_10");
    cyc(1'b0, 32'h00000010, 1'b0, 1'b1, 1'b1, 32'h00500093, 1'b0, 32'h0,        1'b1, 32'h10, "refill_no_fwd");
    // Flush during miss: fill installs, no forward while clr_in is high.
    cyc(1'b1, 32'h00000022, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h10, "miss_20_unaligned");
    cyc(1'b1, 32'h00000020, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h20, "clr_holds_req");
    cyc(1'b1, 32'h00000020, 1'b1, 1'b1, 1'b1, 32'hAABBCCDD, 1'b0, 32'h0,        1'b1, 32'h20, "flush_fill");
    cyc(1'b1, 32'h00000020, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hAABBCCDD, 1'b0, 32'h20, "hit_after_flush");
    cyc(1'b1, 32'h00000020, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h20, "clr_masks_hit");
    // Stall: rdy_in low freezes everything and drops a rdy pulse.
    cyc(1'b1, 32'h00000030, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h20, "miss_30");
    cyc(1'b1, 32'h00000030, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h30, "stall_rdy_pulse");
    cyc(1'b1, 32'h00000020, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h30, "stall_masks_hit");
    cyc(1'b0, 32'h00000030, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h30, "stall_3");
    cyc(1'b1, 32'h00000030, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h30, "post_stall_wait");
    cyc(1'b1, 32'h00000030, 1'b0, 1'b1, 1'b1, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 32'h30, "fill_30");
    cyc(1'b1, 32'h00000030, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h30, "hit_30");
    // Asynchronous reset in the middle of a miss.
    cyc(1'b1, 32'h00000040, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h30, "miss_40");
    cyc(1'b0, 32'h00000040, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40, "req_40");
    rst_in = 1'b1;
    cyc(1'b1, 32'h00000030, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "async_reset");
    rst_in = 1'b0;
    cyc(1'b0, 32'h00000040, 1'b0, 1'b1, 1'b1, 32'h33333333, 1'b0, 32'h0,        1'b0, 32'h0,  "stray_rdy_after_rst");
    cyc(1'b1, 32'h00000020, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  "miss_20_after_rst");
    cyc(1'b0, 32'h00000020, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h20, "req_20_after_rst");
    @(negedge clk_in);
    #1;
    total_cnt++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end else begin
      pass_cnt++;
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
